// File: rtl/hazard_control.sv
// Hazard and sequencing controller for the five-stage core: load-use stalls,
// taken-branch flushes, memory-wait stalls, plus saturating stall/flush counters.
module hazard_control #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_RegDest,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_n;
  logic [3:0] fcnt_q, fcnt_n;
  logic       load_use, mem_stall, flush_evt;

  assign load_use  = ex_MemRead && (ex_RegDest != 5'd0) &&
                     ((dec_use_rs1 && (dec_rs1 == ex_RegDest)) ||
                      (dec_use_rs2 && (dec_rs2 == ex_RegDest)));
  assign mem_stall = mem_req && !mem_ready;

  assign state = rst ? state_q : RUN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_n;
      fcnt_q  <= fcnt_n;
    end
  end

  // MEM_WAIT with mem_ready high falls through to the normal RUN priority chain
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_evt = 1'b0;
    state_n   = state_q;
    fcnt_n    = fcnt_q;
    if (!rst) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
      state_n  = RUN;
      fcnt_n   = 4'd0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if ((state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !mem_ready)) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            state_n  = MEM_WAIT;
          end else if (ex_branch_taken) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              fcnt_n  = FLUSH_LOAD;
              state_n = FLUSH;
            end else begin
              state_n = RUN;
            end
          end else begin
            state_n = RUN;
            if (load_use) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end
        end
        FLUSH: begin
          flush_id = 1'b1;
          if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
          end else begin
            fcnt_n = fcnt_q - 4'd1;
            if (fcnt_q <= 4'd1) state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  // Clear beats increment; both counters stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst || perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Table-driven bench for hazard_control (FLUSH_CYCLES=3, CNT_W=4) with a
// scoreboard queue of expected outputs popped on the falling clock edge.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dec_rs1, dec_rs2, ex_RegDest;
  logic       dec_use_rs1, dec_use_rs2, ex_MemRead, ex_branch_taken;
  logic       mem_req, mem_ready, perf_clr;
  logic       stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex;
  logic [1:0] state;
  logic [3:0] stall_count, flush_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_control #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_MemRead(ex_MemRead), .ex_RegDest(ex_RegDest),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .flush_ex(flush_ex),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  // ctl packs {stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex}
  typedef struct {
    logic       rst;
    logic       br, mreq, mrdy, clr;
    logic [1:0] lu;
    logic [5:0] ctl;
    logic [1:0] st;
    logic [3:0] sc, fc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic b, input logic mq, input logic mr,
                              input logic [1:0] l, input logic c, input logic [5:0] ctl,
                              input logic [1:0] st, input int sc, input int fc);
    vec_t v;
    v.rst = r; v.br = b; v.mreq = mq; v.mrdy = mr; v.lu = l; v.clr = c;
    v.ctl = ctl; v.st = st; v.sc = 4'(sc); v.fc = 4'(fc);
    return v;
  endfunction

  // lu: 0 none, 1 load-use on rs2=x5, 2 load to x0 read via rs1, 3 rs1 matches but unused
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst             = v.rst;
    ex_branch_taken = v.br;
    mem_req         = v.mreq;
    mem_ready       = v.mrdy;
    perf_clr        = v.clr;
    ex_MemRead      = (v.lu != 2'd0);
    case (v.lu)
      2'd1:    begin ex_RegDest = 5'd5; dec_rs1 = 5'd3; dec_use_rs1 = 1'b1; dec_rs2 = 5'd5; dec_use_rs2 = 1'b1; end
      2'd2:    begin ex_RegDest = 5'd0; dec_rs1 = 5'd0; dec_use_rs1 = 1'b1; dec_rs2 = 5'd0; dec_use_rs2 = 1'b0; end
      2'd3:    begin ex_RegDest = 5'd7; dec_rs1 = 5'd7; dec_use_rs1 = 1'b0; dec_rs2 = 5'd2; dec_use_rs2 = 1'b1; end
      default: begin ex_RegDest = 5'd0; dec_rs1 = 5'd0; dec_use_rs1 = 1'b0; dec_rs2 = 5'd0; dec_use_rs2 = 1'b0; end
    endcase
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [5:0] ctl;
    ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex};
    compared += 4;
    if (ctl !== v.ctl) begin
      mismatched++;
      $display("[TB] FAIL ctl vec %0d: got %b expected %b", idx, ctl, v.ctl);
    end
    if (state !== v.st) begin
      mismatched++;
      $display("[TB] FAIL state vec %0d: got %0d expected %0d", idx, state, v.st);
    end
    if (stall_count !== v.sc) begin
      mismatched++;
      $display("[TB] FAIL stall_count vec %0d: got %0d expected %0d", idx, stall_count, v.sc);
    end
    if (flush_count !== v.fc) begin
      mismatched++;
      $display("[TB] FAIL flush_count vec %0d: got %0d expected %0d", idx, flush_count, v.fc);
    end
  endtask

  int checked_idx = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front(), checked_idx);
      checked_idx++;
    end
  end

  initial begin
    rst = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
    ex_MemRead = 1'b0; ex_RegDest = 5'd0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    repeat (2) @(posedge clk);

    // reset, load-use, x0 destination, unused source
    vecs.push_back(mk(0,0,0,0,0,0,6'b000011,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0,6'b110100,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,1,0));
    vecs.push_back(mk(1,0,0,0,2,0,6'b000000,0,1,0));
    vecs.push_back(mk(1,0,0,0,3,0,6'b000000,0,1,0));
    // taken branch: state 0,2,2,0
    vecs.push_back(mk(1,1,0,0,0,0,6'b000011,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000010,2,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000010,2,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,1,1));
    // four-cycle memory wait
    vecs.push_back(mk(1,0,1,0,0,0,6'b111000,0,1,1));
    vecs.push_back(mk(1,0,1,0,0,0,6'b111000,1,2,1));
    vecs.push_back(mk(1,0,1,0,0,0,6'b111000,1,3,1));
    vecs.push_back(mk(1,0,1,0,0,0,6'b111000,1,4,1));
    vecs.push_back(mk(1,0,1,1,0,0,6'b000000,1,5,1));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,5,1));
    // branch held through memory wait, then memory stall inside FLUSH
    vecs.push_back(mk(1,1,1,0,0,0,6'b111000,0,5,1));
    vecs.push_back(mk(1,1,1,0,0,0,6'b111000,1,6,1));
    vecs.push_back(mk(1,1,1,1,0,0,6'b000011,1,7,1));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000010,2,7,2));
    vecs.push_back(mk(1,0,1,0,0,0,6'b111010,2,7,2));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000010,2,8,2));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,8,2));
    // branch plus load-use, then reset with the flush counter at 2
    vecs.push_back(mk(1,1,0,0,1,0,6'b000011,0,8,2));
    vecs.push_back(mk(0,0,0,0,0,0,6'b000011,0,8,3));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,0,0));
    // load-use evaluated on the mem_ready cycle
    vecs.push_back(mk(1,0,1,0,0,0,6'b111000,0,0,0));
    vecs.push_back(mk(1,0,1,1,1,0,6'b110100,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,2,0));
    // long stall to saturate stall_count at 15
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1,0,1,0,0,0,6'b111000,(i == 0) ? 2'd0 : 2'd1,
                        (2 + i > 15) ? 15 : 2 + i, 0));
    vecs.push_back(mk(1,0,1,1,0,0,6'b000000,1,15,0));
    // perf_clr together with a stall
    vecs.push_back(mk(1,0,1,0,0,1,6'b111000,0,15,0));
    vecs.push_back(mk(1,0,1,1,0,0,6'b000000,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,6'b000000,0,0,0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0 || checked_idx != vecs.size()) begin
      mismatched++;
      $display("[TB] FAIL drain: checked %0d expected %0d", checked_idx, vecs.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It sits beside the decode stage and drives the stall, flush and bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions: load-use data hazards, taken branches and jumps, and multi-cycle memory accesses. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles `flush_id` is held after a taken branch/jump (1..15); covers fetch latency.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- dec_rs1, dec_rs2  input  5 each  source registers of the instruction in decode.
- dec_use_rs1, dec_use_rs2  input  1 each  decoded instruction actually reads that source.
- ex_MemRead  input  1  instruction in execute is a load.
- ex_RegDest  input  5  destination register of the instruction in execute.
- ex_branch_taken  input  1  execute resolved a taken branch/JAL/JALR (PCSrc).
- mem_req  input  1  memory stage holds an access this cycle.
- mem_ready  input  1  memory completes the access this cycle.
- perf_clr  input  1  synchronous clear of both counters.
- stall_if, stall_id, stall_ex  output  1 each  hold the PC / IF-ID / ID-EX registers.
- bubble_ex  output  1  load a NOP (all control signals 0) into ID/EX.
- flush_id, flush_ex  output  1 each  replace IF/ID / ID/EX contents with NOP.
- state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH.
- stall_count  output  CNT_W  cycles with `stall_if`=1, saturating.
- flush_count  output  CNT_W  taken-branch events, saturating.

## Operation
- Define `load_use` = `ex_MemRead` & (`ex_RegDest`≠0) & ((`dec_use_rs1` & `dec_rs1`==`ex_RegDest`) | (`dec_use_rs2` & `dec_rs2`==`ex_RegDest`)).
- Define `mem_stall` = `mem_req` & !`mem_ready`.
- Control outputs are combinational from the state register and the current inputs. The state, flush down-counter (4 bits) and perf counters are registered.
- Evaluation order in RUN (first match wins):
  1. `mem_stall`: `stall_if`=`stall_id`=`stall_ex`=1. Next state is MEM_WAIT.
  2. `ex_branch_taken`: `flush_id`=`flush_ex`=1. `flush_count`+1. If FLUSH_CYCLES>1, load the down-counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN. No stall.
  3. `load_use`: `stall_if`=`stall_id`=1 and `bubble_ex`=1. Stay in RUN. The bubble clears `ex_MemRead`, so the stall lasts exactly one cycle.
  4. Otherwise all controls are 0.
- MEM_WAIT:
  - While `mem_ready`=0, `stall_if`=`stall_id`=`stall_ex`=1; branch and load-use inputs are ignored.
  - In the cycle `mem_ready`=1, evaluate exactly as RUN with `mem_stall`=0, including branch flush and load-use. The next state is what RUN would choose.
- FLUSH:
  - `flush_id`=1 each cycle; the counter decrements. When the counter is 1, the next state is RUN.
  - `mem_stall` in FLUSH: assert all three stalls, keep `flush_id`=1, freeze the counter and stay in FLUSH.
  - A new `ex_branch_taken` in FLUSH is not possible (`flush_ex` was issued) and is ignored.
- Counters:
  - `stall_count` increments on each cycle with `stall_if`=1 and holds at 2^CNT_W-1.
  - `flush_count` holds at its maximum likewise.
  - `perf_clr` zeroes both counters and wins over any increment in the same cycle.

## Timing
- Reset (`rst`=0 at a clock edge): state←RUN, down-counter←0, both counters←0.
- While `rst`=0: `flush_id`=`flush_ex`=1; `stall_if`, `stall_id`, `stall_ex` and `bubble_ex` are 0; `state` reads 0.
- Reset mid-MEM_WAIT or mid-FLUSH returns to RUN on that edge; no stall persists after `rst` returns to 1.
- Latency:
  - Controls react in the same cycle as their inputs (zero cycles).
  - The state change is visible one cycle later.
  - A load-use stall costs 1 cycle.
  - A taken branch costs FLUSH_CYCLES flush cycles.
  - A memory wait of N cycles with `mem_ready`=0 costs N stall cycles.
- Simultaneous events:
  - `mem_stall` together with `ex_branch_taken`: stall first. The branch is re-evaluated when `mem_ready` rises, because execute is frozen.
  - `ex_branch_taken` together with `load_use`: flush only, no bubble, no stall.
- A register x0 destination never causes a load-use stall.

## Test plan
- **Load-use:** `ex_MemRead`=1, `ex_RegDest`=5, `dec_rs2`=5, `dec_use_rs2`=1 → for one cycle `stall_if`=`stall_id`=`bubble_ex`=1 and `stall_count`=1. With `ex_RegDest`=0 and `dec_rs1`=0 → no stall.
- **Branch, FLUSH_CYCLES=3:** pulse `ex_branch_taken` → `flush_ex` high for 1 cycle; `flush_id` high for 3 consecutive cycles; `state` goes 0,2,2,0; `flush_count`=1.
- **Memory wait:** `mem_req`=1, `mem_ready`=0 for 4 cycles then 1 → all stalls high for 4 cycles, low on the ready cycle; `state` reads 1 for 4 cycles, then 0; `stall_count`=4.
- **Simultaneous events:** branch during memory wait (`ex_branch_taken`=1 held) → no flush until `mem_ready`=1, then the flush fires in that same cycle. Branch plus load-use in the same cycle → `flush_id`=`flush_ex`=1 and `bubble_ex`=0.
- **Reset and counters:** assert `rst`=0 during FLUSH with down-counter 2 → next cycle `state`=0 and counters 0; `flush_id`=`flush_ex`=1 while in reset. Force `stall_count` to 2^CNT_W-1 (CNT_W=4: 15) and continue stalling → it holds at 15. `perf_clr` together with a stall → 0.
